// File: rtl/riscv_pkg.sv
// riscv_pkg - shared RV32IM decode definitions.
//   Opcode / funct3 / funct7 encodings, the bubble instruction word, the
//   SYSTEM words that decode without a CSR access, and the decoded control
//   bundle passed from id_decode_comb to id_stage_pipe.
//   No ports (package).
package riscv_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;   // addi x0,x0,0

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;     // SUB / SRA / SRAI
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_PRIV = 3'b000;           // ECALL/EBREAK/MRET
  localparam logic [2:0] F3_RSVD = 3'b100;           // hole in the CSR funct3 space

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  // Control half of the decoded bundle; operands travel as XLEN-wide ports.
  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic        is_load;
    logic        illegal;
    logic        csr_we;
    logic [11:0] csr_addr;
  } id_ctrl_t;

endpackage

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if - bundle of all decode-stage pipeline signals.
//   slave  : view used by id_stage_pipe (consumes if_id/regfile/ex inputs,
//            drives ready, regfile addresses and the registered outputs).
//   master : view of the surrounding pipeline (or a testbench).
//   Parameters XLEN / REG_AW must match the attached id_stage_pipe.
interface id_stage_pipe_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [31:0]       inst_i;
  logic [XLEN-1:0]   inst_addr_i;
  logic [REG_AW-1:0] rs1_addr_o;
  logic [REG_AW-1:0] rs2_addr_o;
  logic [XLEN-1:0]   rs1_data_i;
  logic [XLEN-1:0]   rs2_data_i;
  logic              flush_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [XLEN-1:0]   op1_o;
  logic [XLEN-1:0]   op2_o;
  logic [XLEN-1:0]   op1_jump_o;
  logic [XLEN-1:0]   op2_jump_o;
  logic [31:0]       inst_o;
  logic [XLEN-1:0]   inst_addr_o;
  logic [XLEN-1:0]   rs1_data_o;
  logic [XLEN-1:0]   rs2_data_o;
  logic              reg_we_o;
  logic [REG_AW-1:0] reg_waddr_o;
  logic              is_load_o;
  logic              illegal_o;
  logic [11:0]       csr_raddr_o;
  logic [11:0]       csr_waddr_o;
  logic              csr_we_o;

  modport slave (
    input  in_valid_i, inst_i, inst_addr_i, rs1_data_i, rs2_data_i, flush_i, out_ready_i,
    output in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o, op1_o, op2_o, op1_jump_o,
           op2_jump_o, inst_o, inst_addr_o, rs1_data_o, rs2_data_o, reg_we_o, reg_waddr_o,
           is_load_o, illegal_o, csr_raddr_o, csr_waddr_o, csr_we_o
  );

  modport master (
    output in_valid_i, inst_i, inst_addr_i, rs1_data_i, rs2_data_i, flush_i, out_ready_i,
    input  in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o, op1_o, op2_o, op1_jump_o,
           op2_jump_o, inst_o, inst_addr_o, rs1_data_o, rs2_data_o, reg_we_o, reg_waddr_o,
           is_load_o, illegal_o, csr_raddr_o, csr_waddr_o, csr_we_o
  );
endinterface

// File: rtl/id_decode_comb.sv
// id_decode_comb - purely combinational RV32IM instruction decoder.
//   i_inst / i_pc           instruction word and its PC
//   i_rs1_data / i_rs2_data regfile read data
//   o_op1 / o_op2           ALU operands
//   o_jop1 / o_jop2         address / jump-target operands
//   o_ctrl                  write-back, load, illegal and CSR control
//   o_rs1_used / o_rs2_used instruction really reads rs1 / rs2 (hazard check)
// Optional feature: ID_CSR_DECODE_EN enables SYSTEM/CSR decode; without it
// the whole SYSTEM opcode is illegal.
module id_decode_comb
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  output logic [XLEN-1:0] o_op1,
  output logic [XLEN-1:0] o_op2,
  output logic [XLEN-1:0] o_jop1,
  output logic [XLEN-1:0] o_jop2,
  output id_ctrl_t        o_ctrl,
  output logic            o_rs1_used,
  output logic            o_rs2_used
);

  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt, w_four;

  assign w_opc = i_inst[6:0];
  assign w_rd  = i_inst[11:7];
  assign w_f3  = i_inst[14:12];
  assign w_rs1 = i_inst[19:15];
  assign w_rs2 = i_inst[24:20];
  assign w_f7  = i_inst[31:25];

  assign w_imm_i = XLEN'($signed(i_inst[31:20]));
  assign w_imm_s = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
  assign w_imm_b = XLEN'($signed({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({i_inst[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0}));
  assign w_shamt = XLEN'(i_rs2_data[4:0]);
  assign w_four  = XLEN'(3'd4);

  logic            w_legal, w_oor;
  logic [XLEN-1:0] w_op1, w_op2, w_jop1, w_jop2;
  id_ctrl_t        w_ctrl;
  logic            w_rs1u, w_rs2u;

  always_comb begin
    w_legal = 1'b0;
    w_op1   = '0;
    w_op2   = '0;
    w_jop1  = '0;
    w_jop2  = '0;
    w_ctrl  = '0;
    w_rs1u  = 1'b0;
    w_rs2u  = 1'b0;
    w_ctrl.waddr = w_rd;
    case (w_opc)
      OPC_LUI: begin
        w_legal = 1'b1; w_ctrl.we = 1'b1;
        w_op1   = w_imm_u;
      end
      OPC_AUIPC: begin
        w_legal = 1'b1; w_ctrl.we = 1'b1;
        w_op1   = i_pc; w_op2 = w_imm_u;
      end
      OPC_JAL: begin
        w_legal = 1'b1; w_ctrl.we = 1'b1;
        w_op1   = i_pc; w_op2 = w_four;
        w_jop1  = i_pc; w_jop2 = w_imm_j;
      end
      OPC_JALR: begin
        w_legal = (w_f3 == F3_ADD); w_ctrl.we = 1'b1; w_rs1u = 1'b1;
        w_op1   = i_pc; w_op2 = w_four;
        w_jop1  = i_rs1_data; w_jop2 = w_imm_i;
      end
      OPC_BRANCH: begin
        w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
        w_rs1u  = 1'b1; w_rs2u = 1'b1;
        w_op1   = i_rs1_data; w_op2 = i_rs2_data;
        w_jop1  = i_pc; w_jop2 = w_imm_b;
      end
      OPC_LOAD: begin
        w_legal = (w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        w_ctrl.we = 1'b1; w_ctrl.is_load = 1'b1; w_rs1u = 1'b1;
        w_jop1  = i_rs1_data; w_jop2 = w_imm_i;
      end
      OPC_STORE: begin
        w_legal = (w_f3 inside {3'b000, 3'b001, 3'b010});
        w_rs1u  = 1'b1; w_rs2u = 1'b1;
        w_op2   = i_rs2_data;
        w_jop1  = i_rs1_data; w_jop2 = w_imm_s;
      end
      OPC_OPIMM: begin
        // immediate shifts carry funct7 in the upper immediate bits
        if (w_f3 == F3_SLL)     w_legal = (w_f7 == F7_BASE);
        else if (w_f3 == F3_SR) w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
        else                    w_legal = 1'b1;
        w_ctrl.we = 1'b1; w_rs1u = 1'b1;
        w_op1   = i_rs1_data; w_op2 = w_imm_i;
      end
      OPC_OP: begin
        w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_MULDIV) ||
                  ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD) || (w_f3 == F3_SR)));
        w_ctrl.we = 1'b1; w_rs1u = 1'b1; w_rs2u = 1'b1;
        w_op1   = i_rs1_data;
        // register shifts only see the low five bits of rs2
        w_op2   = ((w_f7 != F7_MULDIV) && ((w_f3 == F3_SLL) || (w_f3 == F3_SR))) ?
                  w_shamt : i_rs2_data;
      end
      OPC_SYSTEM: begin
`ifdef ID_CSR_DECODE_EN
        if (w_f3 == F3_PRIV) begin
          w_legal = (i_inst == INST_ECALL) || (i_inst == INST_EBREAK) || (i_inst == INST_MRET);
        end else if (w_f3 != F3_RSVD) begin
          w_legal         = 1'b1;
          w_ctrl.we       = 1'b1;
          w_ctrl.csr_addr = i_inst[31:20];
          w_rs1u          = !w_f3[2];
          w_op1           = w_f3[2] ? XLEN'(w_rs1) : i_rs1_data;
          // set/clear with a zero source leaves the CSR untouched
          w_ctrl.csr_we   = !(w_f3[1] && (w_rs1 == 5'd0));
        end
`endif
      end
      default: ;
    endcase

    // register indices beyond REG_AW (RV32E) are illegal only where used
    w_oor = (w_ctrl.we && ((w_rd  >> REG_AW) != 5'd0)) ||
            (w_rs1u    && ((w_rs1 >> REG_AW) != 5'd0)) ||
            (w_rs2u    && ((w_rs2 >> REG_AW) != 5'd0));
  end

  always_comb begin
    o_op1      = w_op1;
    o_op2      = w_op2;
    o_jop1     = w_jop1;
    o_jop2     = w_jop2;
    o_ctrl     = w_ctrl;
    o_rs1_used = w_rs1u;
    o_rs2_used = w_rs2u;
    if (!w_legal || w_oor) begin
      o_op1      = '0;
      o_op2      = '0;
      o_jop1     = '0;
      o_jop2     = '0;
      o_ctrl     = '0;
      o_ctrl.illegal = 1'b1;
      o_rs1_used = 1'b0;
      o_rs2_used = 1'b0;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe - registered RV32IM decode stage between if_id and ex.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : id_stage_pipe_if.slave - input handshake (in_valid/in_ready,
//              inst, PC), regfile read addr/data, flush, output handshake
//              (out_valid/out_ready) and the registered decode result.
// Holds one decoded instruction; inserts a bubble on a load-use hazard and
// kills held/incoming instructions on flush.
// Optional feature: ID_CSR_DECODE_EN drives the CSR outputs; otherwise they
// are constant 0 and SYSTEM instructions decode as illegal.
module id_stage_pipe
  import riscv_pkg::*;
#(
  parameter int          XLEN   = 32,
  parameter int          REG_AW = 5,
  parameter logic [31:0] NOP    = NOP_INST
) (
  input  logic           clk,
  input  logic           rst,
  id_stage_pipe_if.slave bus
);

  logic [XLEN-1:0] w_op1, w_op2, w_jop1, w_jop2;
  id_ctrl_t        w_ctrl;
  logic            w_rs1_used, w_rs2_used;

  id_decode_comb #(.XLEN(XLEN), .REG_AW(REG_AW)) u_dec (
    .i_inst     (bus.inst_i),
    .i_pc       (bus.inst_addr_i),
    .i_rs1_data (bus.rs1_data_i),
    .i_rs2_data (bus.rs2_data_i),
    .o_op1      (w_op1),
    .o_op2      (w_op2),
    .o_jop1     (w_jop1),
    .o_jop2     (w_jop2),
    .o_ctrl     (w_ctrl),
    .o_rs1_used (w_rs1_used),
    .o_rs2_used (w_rs2_used)
  );

  logic              r_valid;
  logic [31:0]       r_inst;
  logic [XLEN-1:0]   r_pc, r_op1, r_op2, r_jop1, r_jop2, r_rs1, r_rs2;
  id_ctrl_t          r_ctrl;
  logic [REG_AW-1:0] w_waddr;
  logic [REG_AW-1:0] w_rs1_addr, w_rs2_addr;
  logic              w_hazard, w_free, w_fire, w_upd;

  assign w_rs1_addr = bus.inst_i[15 +: REG_AW];
  assign w_rs2_addr = bus.inst_i[20 +: REG_AW];
  assign w_waddr    = r_ctrl.waddr[REG_AW-1:0];

  // a held load whose result the incoming instruction needs; x0 never stalls
  assign w_hazard = r_valid && r_ctrl.is_load && (w_waddr != '0) && bus.in_valid_i &&
                    ((w_rs1_used && (w_rs1_addr == w_waddr)) ||
                     (w_rs2_used && (w_rs2_addr == w_waddr)));
  assign w_free   = !r_valid || bus.out_ready_i;
  assign bus.in_ready_o = w_free && !w_hazard && !bus.flush_i;
  assign w_fire   = bus.in_valid_i && bus.in_ready_o;
  // flush clears even a stalled register; otherwise update only when it frees.
  // A free register with no transfer loads a bubble.
  assign w_upd    = bus.flush_i || w_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_inst  <= NOP;
      r_pc    <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_jop1  <= '0;
      r_jop2  <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_ctrl  <= '0;
    end else if (w_upd) begin
      r_valid <= w_fire;
      r_inst  <= w_fire ? bus.inst_i      : NOP;
      r_pc    <= w_fire ? bus.inst_addr_i : '0;
      r_op1   <= w_fire ? w_op1           : '0;
      r_op2   <= w_fire ? w_op2           : '0;
      r_jop1  <= w_fire ? w_jop1          : '0;
      r_jop2  <= w_fire ? w_jop2          : '0;
      r_rs1   <= w_fire ? bus.rs1_data_i  : '0;
      r_rs2   <= w_fire ? bus.rs2_data_i  : '0;
      r_ctrl  <= w_fire ? w_ctrl          : '0;
    end
  end

  assign bus.rs1_addr_o  = w_rs1_addr;
  assign bus.rs2_addr_o  = w_rs2_addr;
  assign bus.out_valid_o = r_valid;
  assign bus.op1_o       = r_op1;
  assign bus.op2_o       = r_op2;
  assign bus.op1_jump_o  = r_jop1;
  assign bus.op2_jump_o  = r_jop2;
  assign bus.inst_o      = r_inst;
  assign bus.inst_addr_o = r_pc;
  assign bus.rs1_data_o  = r_rs1;
  assign bus.rs2_data_o  = r_rs2;
  assign bus.reg_we_o    = r_ctrl.we;
  assign bus.reg_waddr_o = w_waddr;
  assign bus.is_load_o   = r_ctrl.is_load;
  assign bus.illegal_o   = r_ctrl.illegal;

`ifdef ID_CSR_DECODE_EN
  assign bus.csr_raddr_o = r_ctrl.csr_addr;
  assign bus.csr_waddr_o = r_ctrl.csr_addr;
  assign bus.csr_we_o    = r_ctrl.csr_we;
`else
  logic w_unused_csr;
  assign w_unused_csr    = ^{r_ctrl.csr_we, r_ctrl.csr_addr};
  assign bus.csr_raddr_o = '0;
  assign bus.csr_waddr_o = '0;
  assign bus.csr_we_o    = 1'b0;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe - directed self-checking bench for id_stage_pipe.
// Two instances: RV32I (REG_AW=5) carries most vectors; RV32E (REG_AW=4)
// checks the register-range illegal case. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_id_stage_pipe;

  localparam logic [31:0] NOPW   = 32'h0000_0013;
  localparam logic [31:0] I_ADDI = 32'hFFD0_8293;  // addi x5,x1,-3
  localparam logic [31:0] I_SRA  = 32'h4020_D433;  // sra  x8,x1,x2
  localparam logic [31:0] I_JAL  = 32'h0100_00EF;  // jal  x1,+16
  localparam logic [31:0] I_LUI  = 32'h1234_54B7;  // lui  x9,0x12345
  localparam logic [31:0] I_DIV  = 32'h0220_C533;  // div  x10,x1,x2
  localparam logic [31:0] I_LW   = 32'h0001_2303;  // lw   x6,0(x2)
  localparam logic [31:0] I_ADD  = 32'h0013_03B3;  // add  x7,x6,x1
  localparam logic [31:0] I_BEQ  = 32'h0020_8463;  // beq  x1,x2,+8
  localparam logic [31:0] I_A17  = 32'h0020_88B3;  // add  x17,x1,x2
  localparam logic [31:0] I_BAD  = 32'h0000_007F;
  localparam logic [31:0] I_CSRS = 32'h3000_21F3;  // csrrs x3,mstatus,x0
  localparam logic [31:0] RS1V   = 32'd10;
  localparam logic [31:0] RS2V   = 32'h1234_5678;

  logic clk, rst;
  int   n_chk, n_fail;

  id_stage_pipe_if #(.XLEN(32), .REG_AW(5)) bus ();
  id_stage_pipe_if #(.XLEN(32), .REG_AW(4)) bus_e ();

  id_stage_pipe #(.XLEN(32), .REG_AW(5)) u_dut   (.clk(clk), .rst(rst), .bus(bus));
  id_stage_pipe #(.XLEN(32), .REG_AW(4)) u_dut_e (.clk(clk), .rst(rst), .bus(bus_e));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  // present one instruction for exactly one edge (out_ready assumed 1)
  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid_i  = 1'b1;
    bus.inst_i      = inst;
    bus.inst_addr_i = pc;
    edge1();
    bus.in_valid_i  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    bus.in_valid_i = 1'b0;   bus.inst_i = NOPW;   bus.inst_addr_i = '0;
    bus.rs1_data_i = RS1V;   bus.rs2_data_i = RS2V;
    bus.flush_i = 1'b0;      bus.out_ready_i = 1'b1;
    bus_e.in_valid_i = 1'b0; bus_e.inst_i = NOPW; bus_e.inst_addr_i = '0;
    bus_e.rs1_data_i = RS1V; bus_e.rs2_data_i = RS2V;
    bus_e.flush_i = 1'b0;    bus_e.out_ready_i = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.out_valid_o, 0);
    chk("rst_inst",  bus.inst_o, NOPW);
    chk("rst_we",    bus.reg_we_o, 0);
    chk("rst_op1",   bus.op1_o, 0);
    edge1(); rst = 1'b0;

    // ADDI: 1-cycle latency, sign-extended immediate
    bus.in_valid_i = 1'b1; bus.inst_i = I_ADDI; bus.inst_addr_i = 32'h100;
    @(negedge clk);
    chk("addi_rdy",   bus.in_ready_o, 1);
    chk("addi_rs1a",  bus.rs1_addr_o, 1);
    chk("addi_pre_v", bus.out_valid_o, 0);
    edge1(); bus.in_valid_i = 1'b0;
    @(negedge clk);
    chk("addi_valid", bus.out_valid_o, 1);
    chk("addi_op1",   bus.op1_o, RS1V);
    chk("addi_op2",   bus.op2_o, 32'hFFFF_FFFD);
    chk("addi_we",    bus.reg_we_o, 1);
    chk("addi_wa",    bus.reg_waddr_o, 5);
    chk("addi_pc",    bus.inst_addr_o, 32'h100);

    send(I_SRA, 32'h104);
    chk("sra_op1", bus.op1_o, RS1V);
    chk("sra_op2", bus.op2_o, 32'h18);
    send(I_JAL, 32'h200);
    chk("jal_op1",  bus.op1_o, 32'h200);
    chk("jal_op2",  bus.op2_o, 4);
    chk("jal_jop1", bus.op1_jump_o, 32'h200);
    chk("jal_jop2", bus.op2_jump_o, 16);
    send(I_LUI, 32'h204);
    chk("lui_op1", bus.op1_o, 32'h1234_5000);
    chk("lui_op2", bus.op2_o, 0);
    send(I_DIV, 32'h208);
    chk("div_op2", bus.op2_o, RS2V);
    chk("div_ill", bus.illegal_o, 0);
    send(NOPW, 32'h20C);
    chk("x0_we", bus.reg_we_o, 1);
    chk("x0_wa", bus.reg_waddr_o, 0);

    // load-use: LW x6 then ADD using x6 -> one bubble
    bus.in_valid_i = 1'b1; bus.inst_i = I_LW; bus.inst_addr_i = 32'h140;
    edge1();
    bus.inst_i = I_ADD; bus.inst_addr_i = 32'h144;
    @(negedge clk);
    chk("lw_isload", bus.is_load_o, 1);
    chk("lw_jop1",   bus.op1_jump_o, RS1V);
    chk("lu_stall",  bus.in_ready_o, 0);
    edge1();
    @(negedge clk);
    chk("lu_bub_v",  bus.out_valid_o, 0);
    chk("lu_bub_i",  bus.inst_o, NOPW);
    chk("lu_rdy",    bus.in_ready_o, 1);
    edge1(); bus.in_valid_i = 1'b0;
    @(negedge clk);
    chk("lu_add_v",  bus.out_valid_o, 1);
    chk("lu_add_i",  bus.inst_o, I_ADD);
    chk("lu_add_wa", bus.reg_waddr_o, 7);

    // back-pressure: 3 cycles held, then next instruction in 1 cycle
    bus.out_ready_i = 1'b0;
    bus.in_valid_i = 1'b1; bus.inst_i = I_ADDI; bus.inst_addr_i = 32'h300;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_rdy",  bus.in_ready_o, 0);
      chk("bp_inst", bus.inst_o, I_ADD);
      chk("bp_vld",  bus.out_valid_o, 1);
      edge1();
    end
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_rel_rdy", bus.in_ready_o, 1);
    edge1(); bus.in_valid_i = 1'b0;
    @(negedge clk);
    chk("bp_rel_inst", bus.inst_o, I_ADDI);
    chk("bp_rel_pc",   bus.inst_addr_o, 32'h300);

    // flush while holding BEQ with an incoming instruction
    send(I_BEQ, 32'h400);
    chk("beq_jop1", bus.op1_jump_o, 32'h400);
    chk("beq_jop2", bus.op2_jump_o, 8);
    chk("beq_we",   bus.reg_we_o, 0);
    bus.out_ready_i = 1'b0;
    bus.in_valid_i = 1'b1; bus.inst_i = I_ADDI; bus.inst_addr_i = 32'h404;
    bus.flush_i = 1'b1;
    #1;
    chk("fl_rdy", bus.in_ready_o, 0);
    edge1();
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("fl_valid", bus.out_valid_o, 0);
    chk("fl_inst",  bus.inst_o, NOPW);
    edge1();
    @(negedge clk);
    chk("fl_drop", bus.out_valid_o, 0);

    // unknown opcode
    send(I_BAD, 32'h500);
    chk("bad_valid", bus.out_valid_o, 1);
    chk("bad_ill",   bus.illegal_o, 1);
    chk("bad_we",    bus.reg_we_o, 0);
    chk("bad_op1",   bus.op1_o, 0);

    // x17 destination: legal on RV32I, illegal on RV32E
    bus_e.in_valid_i = 1'b1; bus_e.inst_i = I_A17; bus_e.inst_addr_i = 32'h600;
    send(I_A17, 32'h600);
    bus_e.in_valid_i = 1'b0;
    chk("e_ill",   bus_e.illegal_o, 1);
    chk("e_we",    bus_e.reg_we_o, 0);
    chk("i_ill",   bus.illegal_o, 0);
    chk("i_wa",    bus.reg_waddr_o, 17);
    chk("i_op2",   bus.op2_o, RS2V);

    send(I_CSRS, 32'h700);
`ifdef ID_CSR_DECODE_EN
    chk("csr_ill",   bus.illegal_o, 0);
    chk("csr_raddr", bus.csr_raddr_o, 12'h300);
    chk("csr_waddr", bus.csr_waddr_o, 12'h300);
    chk("csr_we",    bus.csr_we_o, 0);
    chk("csr_rwe",   bus.reg_we_o, 1);
`else
    chk("csr_ill",   bus.illegal_o, 1);
    chk("csr_raddr", bus.csr_raddr_o, 0);
    chk("csr_rwe",   bus.reg_we_o, 0);
`endif

    // asynchronous reset mid-operation
    bus.in_valid_i = 1'b1; bus.inst_i = I_ADDI; bus.inst_addr_i = 32'h800;
    edge1(); bus.in_valid_i = 1'b0;
    #1;
    chk("ar_pre_v", bus.out_valid_o, 1);
    rst = 1'b1;
    #1;
    chk("ar_valid", bus.out_valid_o, 0);
    chk("ar_inst",  bus.inst_o, NOPW);
    chk("ar_op2",   bus.op2_o, 0);
    edge1(); rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
